// File: rtl/router_ingress_queue_if.sv
// Ingress valid/ready handshake carrying {addr, data} words into router_ingress_queue.
interface router_ingress_queue_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic [DATA_WIDTH-1:0] in_data;
    logic [1:0]            in_addr;
    logic                  in_valid;
    logic                  in_ready;

    modport master (
        output in_data,
        output in_addr,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_addr,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/router_ingress_queue.sv
// FIFO ingress buffer feeding simple_router: strict arrival order, one word per cycle,
// head-of-line blocking on a stalled destination, registered router-side outputs.
module router_ingress_queue #(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 8,
    localparam int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    router_ingress_queue_if.slave bus,
    input  logic [3:0]            port_stall,
    output logic [DATA_WIDTH-1:0] din,
    output logic                  din_en,
    output logic [1:0]            addr,
    output logic [CNT_W-1:0]      count,
    output logic                  hol_stall
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = DATA_WIDTH + 2;

    logic [ENT_W-1:0]      r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [DATA_WIDTH-1:0] r_din;
    logic                  r_din_en;
    logic [1:0]            r_addr;

    logic [ENT_W-1:0]      w_head;
    logic [1:0]            w_head_addr;
    logic                  w_nonempty;
    logic                  w_ready;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_hol;

    // Handshake and issue decisions; in_ready looks at occupancy only, never at a same-cycle pop.
    always_comb begin
        w_head      = r_mem[r_rd_ptr];
        w_head_addr = w_head[ENT_W-1 -: 2];
        w_nonempty  = (r_count != {CNT_W{1'b0}});
        w_ready     = (r_count < CNT_W'(DEPTH)) & rst;
        w_push      = bus.in_valid & w_ready;
        w_pop       = w_nonempty & ~port_stall[w_head_addr];
        w_hol       = w_nonempty & port_stall[w_head_addr];
    end

    assign bus.in_ready = w_ready;
    assign hol_stall    = w_hol;
    assign din          = r_din;
    assign din_en       = r_din_en;
    assign addr         = r_addr;
    assign count        = r_count;

    // Storage array; contents need no reset because occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {bus.in_addr, bus.in_data};
        end
    end

    // Pointers, occupancy and the registered router interface.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
            r_din    <= {DATA_WIDTH{1'b0}};
            r_din_en <= 1'b0;
            r_addr   <= 2'b00;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_din    <= w_head[DATA_WIDTH-1:0];
                r_addr   <= w_head_addr;
                r_din_en <= 1'b1;
            end else begin
                r_din    <= {DATA_WIDTH{1'b0}};
                r_addr   <= 2'b00;
                r_din_en <= 1'b0;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: tb/tb_router_ingress_queue.sv
// Directed bench for router_ingress_queue with an in-order scoreboard on the router side.
module tb_router_ingress_queue;
    localparam int DW    = 32;
    localparam int DEPTH = 8;

    bit          clk;
    logic        rst;
    logic [3:0]  port_stall;
    logic [DW-1:0] din;
    logic        din_en;
    logic [1:0]  addr;
    logic [3:0]  count;
    logic        hol_stall;

    router_ingress_queue_if #(.DATA_WIDTH(DW)) bus ();

    router_ingress_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .port_stall (port_stall),
        .din        (din),
        .din_en     (din_en),
        .addr       (addr),
        .count      (count),
        .hol_stall  (hol_stall)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit mon_on = 1'b0;
    logic [DW+1:0] sb [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Router-side monitor: every issued word must be the oldest outstanding one; idle outputs are zero.
    always @(negedge clk) begin
        if (mon_on) begin
            if (din_en === 1'b1) begin
                total++;
                assert (sb.size() != 0) else begin
                    bad++;
                    $error("FAIL unexpected_out: observed=%0h expected=none", {addr, din});
                end
                if (sb.size() != 0) begin
                    logic [DW+1:0] e;
                    e = sb.pop_front();
                    chk("out_word", {30'd0, addr, din}, {30'd0, e});
                end
            end else begin
                chk("idle_zero", {30'd0, addr, din}, 64'd0);
            end
        end
    end

    task automatic send(input logic [1:0] a, input logic [DW-1:0] d, output bit acc);
        bus.in_valid = 1'b1;
        bus.in_addr  = a;
        bus.in_data  = d;
        @(negedge clk);
        acc = bus.in_ready;
        if (acc) sb.push_back({a, d});
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        bus.in_valid = 1'b0;
        while (count != 4'd0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk({tag, "_timeout"}, {63'd0, n < 200}, 64'd1);
        chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        bit acc;
        rst          = 1'b0;
        port_stall   = 4'b0000;
        bus.in_valid = 1'b0;
        bus.in_addr  = 2'd0;
        bus.in_data  = '0;

        // Reset state
        @(posedge clk); #1;
        @(posedge clk); #1;
        mon_on = 1'b1;
        @(negedge clk);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_din_en", 64'(din_en), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;

        // Test 1: three back-to-back words, latency of two edges
        bus.in_valid = 1'b1; bus.in_addr = 2'd0; bus.in_data = 32'hA;
        @(negedge clk); chk("t1_ready", 64'(bus.in_ready), 64'd1); sb.push_back({2'd0, 32'hA});
        @(posedge clk); #1; bus.in_addr = 2'd1; bus.in_data = 32'hB;
        @(negedge clk); chk("t1_nobypass", 64'(din_en), 64'd0); sb.push_back({2'd1, 32'hB});
        @(posedge clk); #1; bus.in_addr = 2'd2; bus.in_data = 32'hC;
        @(negedge clk); chk("t1_first", 64'(din_en), 64'd1); sb.push_back({2'd2, 32'hC});
        @(posedge clk); #1; bus.in_valid = 1'b0;
        @(negedge clk); chk("t1_second", 64'(din_en), 64'd1);
        @(negedge clk); chk("t1_third", 64'(din_en), 64'd1);
        @(negedge clk); chk("t1_idle", 64'(din_en), 64'd0); chk("t1_count", 64'(count), 64'd0);
        @(posedge clk); #1;

        // Test 2: fill behind a stalled port 3, then release
        port_stall = 4'b1000;
        for (int i = 0; i < 8; i++) begin
            send(2'd3, 32'h200 + i, acc);
            chk("t2_accept", 64'(acc), 64'd1);
        end
        bus.in_valid = 1'b1; bus.in_addr = 2'd3; bus.in_data = 32'h208;
        @(negedge clk);
        chk("t2_full_ready", 64'(bus.in_ready), 64'd0);
        chk("t2_full_count", 64'(count), 64'd8);
        chk("t2_hol", 64'(hol_stall), 64'd1);
        chk("t2_no_out", 64'(din_en), 64'd0);
        @(posedge clk); #1; port_stall = 4'b0000;
        @(negedge clk);
        chk("t2_still_full", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        chk("t2_ready_after_pop", 64'(bus.in_ready), 64'd1);
        chk("t2_first_pop", 64'(din_en), 64'd1);
        chk("t2_count7", 64'(count), 64'd7);
        sb.push_back({2'd3, 32'h208});
        @(posedge clk); #1; bus.in_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk); chk("t2_stream", 64'(din_en), 64'd1);
        end
        drain("t2");

        // Test 3: head-of-line blocking on port 2
        port_stall = 4'b0100;
        send(2'd2, 32'h1111_0000, acc);
        send(2'd0, 32'h2222_0000, acc);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("t3_no_out", 64'(din_en), 64'd0);
        chk("t3_hol", 64'(hol_stall), 64'd1);
        chk("t3_count", 64'(count), 64'd2);
        @(posedge clk); #1; port_stall = 4'b0000;
        drain("t3");

        // Test 4: simultaneous push and pop at count 4
        port_stall = 4'b1111;
        for (int i = 0; i < 4; i++) send(2'(i), 32'h400 + i, acc);
        port_stall = 4'b0000;
        bus.in_valid = 1'b1; bus.in_addr = 2'd1; bus.in_data = 32'h404;
        @(negedge clk);
        chk("t4_count_before", 64'(count), 64'd4);
        sb.push_back({2'd1, 32'h404});
        @(posedge clk); #1; bus.in_valid = 1'b0;
        @(negedge clk);
        chk("t4_count_after", 64'(count), 64'd4);
        chk("t4_out", 64'(din_en), 64'd1);
        @(posedge clk); #1;
        drain("t4");

        // Test 5: reset with five words pending
        port_stall = 4'b1111;
        for (int i = 0; i < 5; i++) send(2'(i), 32'h500 + i, acc);
        bus.in_valid = 1'b0;
        @(negedge clk); chk("t5_count5", 64'(count), 64'd5);
        @(posedge clk); #1;
        rst = 1'b0; bus.in_valid = 1'b1; bus.in_data = 32'hDEAD;
        @(negedge clk); chk("t5_ready_in_rst", 64'(bus.in_ready), 64'd0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b1; bus.in_valid = 1'b0; port_stall = 4'b0000;
        @(negedge clk);
        chk("t5_count0", 64'(count), 64'd0);
        chk("t5_din_en0", 64'(din_en), 64'd0);
        chk("t5_ready1", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        send(2'd1, 32'h5555, acc);
        chk("t5_accept", 64'(acc), 64'd1);
        drain("t5");

        // Test 6: 20-word stream under random stalls
        for (int i = 0; i < 20; i++) begin
            int tries;
            acc = 1'b0;
            tries = 0;
            while (!acc && tries < 200) begin
                port_stall = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                              ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
                send(2'(i % 4), 32'(i), acc);
                tries++;
            end
            chk("t6_accept", 64'(acc), 64'd1);
        end
        port_stall = 4'b0000;
        drain("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
